hwlp_iv_gen: RTL and testbench

Producer side of the HWLP register file. It walks a nested loop nest of up to N_LP levels and pushes one iteration-variable (IV) tuple per cycle into a shift-register file of HWLP_RF_SIZE entries. Alongside each tuple it exports the per-entry valid, loop-end and per-level restart flags. The HWLP reorder unit consumes these outputs and routes them to the address-generation streams.

---
 rtl/mage_pkg.sv | 26 ++
 rtl/hwlp_iv_counter.sv | 35 +++
 rtl/hwlp_iv_gen.sv | 157 +++++++++++++++
 tb/tb_hwlp_iv_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mage_pkg.sv
// Shared types and sizing for the HWLP iteration-variable generator and register file.
// Level 0 of every per-level vector is the innermost loop.
package mage_pkg;

  localparam int N_LP              = 4;
  localparam int NBIT_LP_IV        = 8;
  localparam int HWLP_RF_SIZE      = 8;
  localparam int LOG2_HWLP_RF_SIZE = $clog2(HWLP_RF_SIZE);
  localparam int NBIT_N_LP         = $clog2(N_LP) + 1;

  typedef logic [NBIT_LP_IV-1:0] hwlp_iv_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } hwlp_gen_state_e;

  typedef struct packed {
    hwlp_iv_t [N_LP-1:0] iv;
    logic [N_LP-1:0]     end_cond;
    logic                end_lp;
    logic                valid;
  } hwlp_entry_t;

endpackage

// File: rtl/hwlp_iv_counter.sv
// One loop level: presents the current IV (init while loading) and its wrap flag combinationally;
// advances on carry_in, reloading init on wrap. No internal backpressure; carry_in is the enable.
module hwlp_iv_counter
  import mage_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  hwlp_iv_t init_val,
  input  hwlp_iv_t end_val,
  input  hwlp_iv_t step_val,
  input  logic     carry_in,
  input  logic     load,
  output hwlp_iv_t iv,
  output logic     wrap
);

  hwlp_iv_t              iv_q;
  logic [NBIT_LP_IV:0]   sum;

  assign iv   = load ? init_val : iv_q;
  // One extra bit so iv+step never aliases below end.
  assign sum  = {1'b0, iv} + {1'b0, step_val};
  assign wrap = sum > {1'b0, end_val};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iv_q <= '0;
    end else if (carry_in) begin
      iv_q <= wrap ? init_val : sum[NBIT_LP_IV-1:0];
    end else if (load) begin
      iv_q <= init_val;
    end
  end

endmodule

// File: rtl/hwlp_iv_gen.sv
// Walks a loop nest, shifting one IV tuple per cycle into an HWLP_RF_SIZE-deep RF; init tuple in entry 0
// one cycle after start. stall_i freezes everything; abort_i flushes to IDLE.
module hwlp_iv_gen
  import mage_pkg::*;
(
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       start_i,
  input  logic                                       abort_i,
  input  logic                                       stall_i,
  input  logic [NBIT_N_LP-1:0]                       reg_n_lp_i,
  input  logic [N_LP*NBIT_LP_IV-1:0]                 reg_lp_init_i,
  input  logic [N_LP*NBIT_LP_IV-1:0]                 reg_lp_end_i,
  input  logic [N_LP*NBIT_LP_IV-1:0]                 reg_lp_step_i,
  output logic [HWLP_RF_SIZE*N_LP*NBIT_LP_IV-1:0]    hwlp_rf_o,
  output logic [HWLP_RF_SIZE-1:0]                    hwlp_valid_o,
  output logic [HWLP_RF_SIZE-1:0]                    end_lp_o,
  output logic [HWLP_RF_SIZE*N_LP-1:0]               hwlp_end_condition_o,
  output logic                                       busy_o,
  output logic                                       done_o
);

  hwlp_gen_state_e      state_q, state_d;
  hwlp_entry_t          rf_q [HWLP_RF_SIZE];
  hwlp_entry_t          new_entry;
  hwlp_iv_t [N_LP-1:0]  init_q, end_q, step_q;
  hwlp_iv_t [N_LP-1:0]  init_c, end_c, step_c, iv;
  logic [N_LP-1:0]      act_q, act_c, wrap, carry, end_cond;
  logic                 idle, accept, adv, shift, final_tuple, acc;

  assign idle   = (state_q == IDLE);
  // A start that coincides with a stall is not taken, since nothing could shift in that cycle.
  assign accept = idle & start_i & ~abort_i & ~stall_i;
  assign adv    = accept | ((state_q == RUN) & ~stall_i & ~abort_i);
  assign shift  = adv | ((state_q == DRAIN) & ~stall_i & ~abort_i);
  assign busy_o = ~idle;

  // In IDLE the counters see the live registers so the init tuple can be pushed on the start cycle.
  always_comb begin
    init_c = init_q;
    end_c  = end_q;
    step_c = step_q;
    act_c  = act_q;
    if (idle) begin
      for (int k = 0; k < N_LP; k++) begin
        act_c[k]  = (k < int'(reg_n_lp_i));
        init_c[k] = '0;
        end_c[k]  = '0;
        step_c[k] = hwlp_iv_t'(1);
        if (act_c[k]) begin
          init_c[k] = reg_lp_init_i[k*NBIT_LP_IV +: NBIT_LP_IV];
          end_c[k]  = reg_lp_end_i[k*NBIT_LP_IV +: NBIT_LP_IV];
          if (reg_lp_step_i[k*NBIT_LP_IV +: NBIT_LP_IV] != '0)
            step_c[k] = reg_lp_step_i[k*NBIT_LP_IV +: NBIT_LP_IV];
        end
      end
    end
  end

  always_comb begin
    acc   = adv;
    carry = '0;
    for (int k = 0; k < N_LP; k++) begin
      carry[k] = acc;
      acc      = acc & wrap[k];
    end
  end

  for (genvar k = 0; k < N_LP; k++) begin : g_lvl
    hwlp_iv_counter u_cnt (
      .clk      (clk_i),
      .rst      (rst_i),
      .init_val (init_c[k]),
      .end_val  (end_c[k]),
      .step_val (step_c[k]),
      .carry_in (carry[k]),
      .load     (idle),
      .iv       (iv[k]),
      .wrap     (wrap[k])
    );
  end

  assign end_cond    = wrap | ~act_c;
  assign final_tuple = &end_cond;

  always_comb begin
    new_entry          = '0;
    new_entry.iv       = iv;
    new_entry.end_cond = end_cond;
    new_entry.end_lp   = final_tuple;
    new_entry.valid    = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    done_o  = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = final_tuple ? DRAIN : RUN;
        RUN:     if (adv && final_tuple) state_d = DRAIN;
        DRAIN: begin
          if (!stall_i && !(|hwlp_valid_o)) begin
            done_o  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      init_q <= '0;
      end_q  <= '0;
      step_q <= '0;
      act_q  <= '0;
    end else if (accept) begin
      init_q <= init_c;
      end_q  <= end_c;
      step_q <= step_c;
      act_q  <= act_c;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int j = 0; j < HWLP_RF_SIZE; j++) rf_q[j] <= '0;
    end else if (abort_i) begin
      for (int j = 0; j < HWLP_RF_SIZE; j++) rf_q[j] <= '0;
    end else if (shift) begin
      rf_q[0] <= adv ? new_entry : '0;
      for (int j = 1; j < HWLP_RF_SIZE; j++) rf_q[j] <= rf_q[j-1];
    end
  end

  always_comb begin
    hwlp_rf_o            = '0;
    hwlp_valid_o         = '0;
    end_lp_o             = '0;
    hwlp_end_condition_o = '0;
    for (int j = 0; j < HWLP_RF_SIZE; j++) begin
      hwlp_rf_o[j*N_LP*NBIT_LP_IV +: N_LP*NBIT_LP_IV] = rf_q[j].iv;
      hwlp_valid_o[j]                                 = rf_q[j].valid;
      end_lp_o[j]                                     = rf_q[j].end_lp;
      hwlp_end_condition_o[j*N_LP +: N_LP]            = rf_q[j].end_cond;
    end
  end

endmodule

// File: tb/tb_hwlp_iv_gen.sv
// Directed bench for hwlp_iv_gen: hand-computed tuple sequences, stall/abort/reset timing.
module tb_hwlp_iv_gen;

  logic         clk = 1'b0;
  logic         rst, start, abort, stall;
  logic [2:0]   n_lp;
  logic [31:0]  init, endv, step;
  logic [255:0] rf;
  logic [7:0]   valid, end_lp;
  logic [31:0]  endc;
  logic         busy, done;
  int           tests = 0;
  int           fails = 0;
  int           done_cnt = 0;
  int           dc;

  hwlp_iv_gen dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .start_i              (start),
    .abort_i              (abort),
    .stall_i              (stall),
    .reg_n_lp_i           (n_lp),
    .reg_lp_init_i        (init),
    .reg_lp_end_i         (endv),
    .reg_lp_step_i        (step),
    .hwlp_rf_o            (rf),
    .hwlp_valid_o         (valid),
    .end_lp_o             (end_lp),
    .hwlp_end_condition_o (endc),
    .busy_o               (busy),
    .done_o               (done)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entry 0: all four IV bytes, end-condition nibble, end_lp, valid.
  task automatic e0(input string tag, input logic [7:0] l0, input logic [7:0] l1,
                    input logic [3:0] ec, input logic el);
    chk(tag, {rf[31:0], endc[3:0], end_lp[0], valid[0]}, {16'h0, l1, l0, ec, el, 1'b1});
  endtask

  // Levels 2/3 get junk values that must never appear while they are inactive.
  task automatic cfg(input logic [2:0] n, input logic [7:0] i0, input logic [7:0] i1,
                     input logic [7:0] en0, input logic [7:0] en1,
                     input logic [7:0] s0, input logic [7:0] s1);
    n_lp = n;
    init = {8'h33, 8'h44, i1, i0};
    endv = {8'hf0, 8'hf0, en1, en0};
    step = {8'h05, 8'h05, s1, s0};
  endtask

  // Scrambles the register inputs after acceptance to prove they were latched.
  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    init  = 32'hdeadbeef;
    endv  = 32'h00000000;
    step  = 32'h01010101;
    n_lp  = 3'd4;
  endtask

  task automatic wait_done(input string tag, input int n);
    for (int i = 1; i < n; i++) tick;
    chk({tag, "_early"}, {busy, done}, 2'b10);
    tick;
    chk(tag, {busy, done, valid}, {1'b1, 1'b1, 8'h00});
    tick;
    chk({tag, "_idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0;
    cfg(3'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1);
    #1;
    chk("reset_ctl", {busy, done, valid, end_lp}, 18'h0);
    chk("reset_data", {|rf, endc}, 33'h0);
    tick; tick;
    rst = 1'b0;
    tick;

    // 2 levels, end={2,1}: six tuples, done 14 cycles after start.
    cfg(3'd2, 8'd0, 8'd0, 8'd2, 8'd1, 8'd1, 8'd1);
    do_start;
    e0("s1_t1", 8'd0, 8'd0, 4'b1100, 1'b0);
    tick; e0("s1_t2", 8'd1, 8'd0, 4'b1100, 1'b0);
    tick; e0("s1_t3", 8'd2, 8'd0, 4'b1101, 1'b0);
    tick; e0("s1_t4", 8'd0, 8'd1, 4'b1110, 1'b0);
    tick; e0("s1_t5", 8'd1, 8'd1, 4'b1110, 1'b0);
    tick; e0("s1_t6", 8'd2, 8'd1, 4'b1111, 1'b1);
    chk("s1_entry3", rf[3*32 +: 32], 32'h0000_0002);
    chk("s1_entry5", rf[5*32 +: 32], 32'h0000_0000);
    chk("s1_flags", {valid, end_lp}, {8'h3f, 8'h01});
    wait_done("s1_done", 8);

    // Same nest with a 3-cycle stall at t+3: done moves to t+17.
    cfg(3'd2, 8'd0, 8'd0, 8'd2, 8'd1, 8'd1, 8'd1);
    do_start;
    tick; e0("s2_t2", 8'd1, 8'd0, 4'b1100, 1'b0);
    tick; e0("s2_t3", 8'd2, 8'd0, 4'b1101, 1'b0);
    stall = 1'b1;
    tick; e0("s2_stall1", 8'd2, 8'd0, 4'b1101, 1'b0);
    chk("s2_stall_valid", valid, 8'h07);
    tick;
    tick; e0("s2_stall3", 8'd2, 8'd0, 4'b1101, 1'b0);
    stall = 1'b0;
    tick; e0("s2_t7", 8'd0, 8'd1, 4'b1110, 1'b0);
    tick; e0("s2_t8", 8'd1, 8'd1, 4'b1110, 1'b0);
    tick; e0("s2_t9", 8'd2, 8'd1, 4'b1111, 1'b1);
    wait_done("s2_done", 8);

    // 1 level, 1..7 step 2; stall exactly on the done cycle.
    cfg(3'd1, 8'd1, 8'd9, 8'd7, 8'd9, 8'd2, 8'd9);
    do_start;
    e0("s3_t1", 8'd1, 8'd0, 4'b1110, 1'b0);
    tick; e0("s3_t2", 8'd3, 8'd0, 4'b1110, 1'b0);
    tick; e0("s3_t3", 8'd5, 8'd0, 4'b1110, 1'b0);
    tick; e0("s3_t4", 8'd7, 8'd0, 4'b1111, 1'b1);
    for (int i = 0; i < 7; i++) tick;
    chk("s3_t11", {busy, done, valid}, {1'b1, 1'b0, 8'h80});
    tick;
    stall = 1'b1;
    #1;
    chk("s3_stall_done", {busy, done, valid}, {1'b1, 1'b0, 8'h00});
    tick;
    chk("s3_stall_done2", {busy, done}, 2'b10);
    stall = 1'b0;
    #1;
    chk("s3_done", {busy, done}, 2'b11);
    tick;
    chk("s3_idle", {busy, done}, 2'b00);

    // step 0 behaves as step 1.
    cfg(3'd1, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0);
    do_start;
    e0("s4_t1", 8'd0, 8'd0, 4'b1110, 1'b0);
    tick; e0("s4_t2", 8'd1, 8'd0, 4'b1110, 1'b0);
    tick; e0("s4_t3", 8'd2, 8'd0, 4'b1111, 1'b1);
    wait_done("s4_done", 8);

    // init > end on level 0; a start in RUN is ignored; reset lands in DRAIN.
    cfg(3'd2, 8'd5, 8'd0, 8'd3, 8'd1, 8'd1, 8'd1);
    do_start;
    e0("s5_t1", 8'd5, 8'd0, 4'b1101, 1'b0);
    cfg(3'd2, 8'd9, 8'd9, 8'd20, 8'd20, 8'd1, 8'd1);
    start = 1'b1;
    tick; e0("s5_t2", 8'd5, 8'd1, 4'b1111, 1'b1);
    start = 1'b0;
    tick; tick;
    chk("s5_drain", {busy, valid}, {1'b1, 8'h0c});
    rst = 1'b1;
    #1;
    chk("s5_rst_ctl", {busy, done, valid, end_lp}, 18'h0);
    chk("s5_rst_data", {|rf, endc}, 33'h0);
    tick;
    rst = 1'b0;
    tick;

    // Abort at t+4 (with stall high); then start+abort in IDLE; then a clean restart.
    cfg(3'd2, 8'd0, 8'd0, 8'd2, 8'd1, 8'd1, 8'd1);
    dc = done_cnt;
    do_start;
    tick; tick; tick;
    e0("s6_t4", 8'd0, 8'd1, 4'b1110, 1'b0);
    abort = 1'b1;
    stall = 1'b1;
    tick;
    abort = 1'b0;
    stall = 1'b0;
    chk("s6_abort", {busy, done, valid, end_lp, endc}, 50'h0);
    cfg(3'd2, 8'd0, 8'd0, 8'd2, 8'd1, 8'd1, 8'd1);
    start = 1'b1;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("s6_abort_start", {busy, valid}, 9'h0);
    chk("s6_no_done", done_cnt, dc);
    do_start;
    e0("s6_restart", 8'd0, 8'd0, 4'b1100, 1'b0);
    chk("s6_busy", busy, 1'b1);
    wait_done("s6_done", 13);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
